// File: rtl/delay_buffer_var.sv
// delay_buffer_var: runtime-selectable circular-RAM complex delay line for the
// radix-4 SDF pipeline. Delay D (1..MAX_DEPTH) is latched on depth_load, which
// also flushes the line. Optional macro DELAY_BUFFER_CLEAR_EN adds a CLEAR state
// that zeroes the whole RAM after reset/depth_load and then starts in RUN with a
// zero-primed pipeline.
module delay_buffer_var #(
    parameter int unsigned MAX_DEPTH = 64,
    parameter int unsigned WIDTH     = 32,
    localparam int unsigned AW       = $clog2(MAX_DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [AW:0]      depth,
    input  logic             depth_load,
    input  logic [WIDTH-1:0] input_real,
    input  logic [WIDTH-1:0] input_imag,
    output logic [WIDTH-1:0] out_real,
    output logic [WIDTH-1:0] out_imag,
    output logic             out_valid,
    output logic             ready
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

`ifdef DELAY_BUFFER_CLEAR_EN
    localparam state_t ST_ENTRY  = ST_CLEAR;
    localparam logic   READY_RST = 1'b0;
`else
    localparam state_t ST_ENTRY  = ST_FILL;
    localparam logic   READY_RST = 1'b1;
`endif

    state_t            state_q, state_nxt;
    logic [AW:0]       d_reg_q, d_reg_nxt;
    logic [AW-1:0]     wptr_q, wptr_nxt;
    logic [AW:0]       fill_q, fill_nxt;
    logic [WIDTH-1:0]  out_real_nxt, out_imag_nxt;
    logic              out_valid_nxt, ready_nxt;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [WIDTH-1:0]  mem_wre, mem_wim;
    logic              accept_c;
    logic              wptr_last_c;
    logic [AW:0]       depth_clamped_c;
`ifdef DELAY_BUFFER_CLEAR_EN
    logic [AW-1:0]     clr_addr_q, clr_addr_nxt;
`endif

    logic [WIDTH-1:0]  mem_re [MAX_DEPTH];
    logic [WIDTH-1:0]  mem_im [MAX_DEPTH];

    // Handshake, pointer wrap and depth clamp helpers
    always_comb begin
        accept_c    = reset_n & enable & ready & ~depth_load;
        wptr_last_c = ({1'b0, wptr_q} == (d_reg_q - (AW+1)'(1)));
        if (depth == '0)
            depth_clamped_c = (AW+1)'(1);
        else if (depth > (AW+1)'(MAX_DEPTH))
            depth_clamped_c = (AW+1)'(MAX_DEPTH);
        else
            depth_clamped_c = depth;
    end

    // State register; reset overrides everything
    always_ff @(posedge clock) begin
        if (!reset_n)
            state_q <= ST_ENTRY;
        else
            state_q <= state_nxt;
    end

    // Next-state logic; depth_load always restarts the line
    always_comb begin
        state_nxt = state_q;
        if (depth_load) begin
            state_nxt = ST_ENTRY;
        end else begin
            case (state_q)
                ST_FILL: if (accept_c && (fill_q == d_reg_q)) state_nxt = ST_RUN;
                ST_RUN:  state_nxt = ST_RUN;
`ifdef DELAY_BUFFER_CLEAR_EN
                ST_CLEAR: if (clr_addr_q == AW'(MAX_DEPTH - 1)) state_nxt = ST_RUN;
`endif
                default: state_nxt = ST_ENTRY;
            endcase
        end
    end

    // Datapath / output next values and RAM write port
    always_comb begin
        d_reg_nxt     = d_reg_q;
        wptr_nxt      = wptr_q;
        fill_nxt      = fill_q;
        out_real_nxt  = out_real;
        out_imag_nxt  = out_imag;
        out_valid_nxt = out_valid;
        ready_nxt     = ready;
        mem_we        = 1'b0;
        mem_addr      = wptr_q;
        mem_wre       = input_real;
        mem_wim       = input_imag;
`ifdef DELAY_BUFFER_CLEAR_EN
        clr_addr_nxt  = clr_addr_q;
`endif
        if (depth_load) begin
            d_reg_nxt     = depth_clamped_c;
            wptr_nxt      = '0;
            fill_nxt      = '0;
            out_real_nxt  = '0;
            out_imag_nxt  = '0;
            out_valid_nxt = 1'b0;
`ifdef DELAY_BUFFER_CLEAR_EN
            ready_nxt     = 1'b0;
            clr_addr_nxt  = '0;
`endif
        end else begin
            case (state_q)
`ifdef DELAY_BUFFER_CLEAR_EN
                ST_CLEAR: begin
                    mem_we       = 1'b1;
                    mem_addr     = clr_addr_q;
                    mem_wre      = '0;
                    mem_wim      = '0;
                    clr_addr_nxt = clr_addr_q + AW'(1);
                    if (clr_addr_q == AW'(MAX_DEPTH - 1)) begin
                        ready_nxt     = 1'b1;
                        out_valid_nxt = 1'b1;
                        wptr_nxt      = '0;
                    end
                end
`endif
                default: begin
                    if (accept_c) begin
                        out_real_nxt = mem_re[wptr_q];
                        out_imag_nxt = mem_im[wptr_q];
                        mem_we       = 1'b1;
                        wptr_nxt     = wptr_last_c ? '0 : wptr_q + AW'(1);
                        if (state_q == ST_FILL) begin
                            if (fill_q == d_reg_q)
                                out_valid_nxt = 1'b1;
                            else
                                fill_nxt = fill_q + (AW+1)'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Control and output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            d_reg_q   <= (AW+1)'(MAX_DEPTH);
            wptr_q    <= '0;
            fill_q    <= '0;
            out_real  <= '0;
            out_imag  <= '0;
            out_valid <= 1'b0;
            ready     <= READY_RST;
`ifdef DELAY_BUFFER_CLEAR_EN
            clr_addr_q <= '0;
`endif
        end else begin
            d_reg_q   <= d_reg_nxt;
            wptr_q    <= wptr_nxt;
            fill_q    <= fill_nxt;
            out_real  <= out_real_nxt;
            out_imag  <= out_imag_nxt;
            out_valid <= out_valid_nxt;
            ready     <= ready_nxt;
`ifdef DELAY_BUFFER_CLEAR_EN
            clr_addr_q <= clr_addr_nxt;
`endif
        end
    end

    // Sample RAM; the read above sees the old word, giving read-before-write
    always_ff @(posedge clock) begin
        if (reset_n && mem_we) begin
            mem_re[mem_addr] <= mem_wre;
            mem_im[mem_addr] <= mem_wim;
        end
    end

endmodule

// File: tb/tb_delay_buffer_var.sv
// Scoreboard bench for delay_buffer_var: a queue-based reference model predicts
// the registered outputs for every clock edge; a monitor checks them mid-cycle.
module tb_delay_buffer_var;

    localparam int unsigned MAX_DEPTH = 64;
    localparam int unsigned WIDTH     = 32;
    localparam int unsigned AW        = $clog2(MAX_DEPTH);

    logic             clock;
    logic             reset_n;
    logic             enable;
    logic [AW:0]      depth;
    logic             depth_load;
    logic [WIDTH-1:0] input_real;
    logic [WIDTH-1:0] input_imag;
    logic [WIDTH-1:0] out_real;
    logic [WIDTH-1:0] out_imag;
    logic             out_valid;
    logic             ready;

    delay_buffer_var #(.MAX_DEPTH(MAX_DEPTH), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .depth      (depth),
        .depth_load (depth_load),
        .input_real (input_real),
        .input_imag (input_imag),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .out_valid  (out_valid),
        .ready      (ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int unsigned      edge_no;
        logic             ready;
        logic             valid;
        logic             known;
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        int unsigned      wptr;
    } exp_t;

    exp_t        sb[$];
    int unsigned edge_cnt = 0;
    int unsigned n_vec    = 0;
    int unsigned n_bad    = 0;

    // Reference model: the line is a FIFO of accepted samples; once it holds
    // more than D entries, each accept pops the sample D accepts older.
    int               m_d;
    logic [2*WIDTH-1:0] m_hist[$];
    int               m_acc;
    int               m_clr;
    logic             m_valid, m_known, m_ready;
    logic [WIDTH-1:0] m_re, m_im;

    always @(posedge clock) edge_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_cnt, act, req);
        end
    endtask

    // Monitor: pop every prediction whose edge has passed and compare
    exp_t e;
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
            e = sb.pop_front();
            chk("ready", 64'(ready), 64'(e.ready));
            chk("out_valid", 64'(out_valid), 64'(e.valid));
            chk("wptr", 64'(dut.wptr_q), 64'(e.wptr));
            if (e.known) begin
                chk("out_real", 64'(out_real), 64'(e.re));
                chk("out_imag", 64'(out_imag), 64'(e.im));
            end
        end
    end

    task automatic model_flush();
        m_hist.delete();
        m_acc   = 0;
        m_valid = 1'b0;
        m_known = 1'b1;
        m_re    = '0;
        m_im    = '0;
`ifdef DELAY_BUFFER_CLEAR_EN
        m_ready = 1'b0;
        m_clr   = MAX_DEPTH;
`else
        m_ready = 1'b1;
        m_clr   = 0;
`endif
    endtask

    // Drive one cycle of inputs, advance the model, queue the prediction
    task automatic step(input logic rst, input logic en, input logic ld,
                        input logic [AW:0] dep, input logic [WIDTH-1:0] re,
                        input logic [WIDTH-1:0] im);
        exp_t x;
        int dv;
        logic [2*WIDTH-1:0] s;
        reset_n    = rst;
        enable     = en;
        depth_load = ld;
        depth      = dep;
        input_real = re;
        input_imag = im;
        if (!rst) begin
            m_d = MAX_DEPTH;
            model_flush();
        end else if (ld) begin
            dv = int'(dep);
            if (dv == 0) dv = 1;
            if (dv > int'(MAX_DEPTH)) dv = MAX_DEPTH;
            m_d = dv;
            model_flush();
        end else if (m_clr > 0) begin
            m_clr--;
            if (m_clr == 0) begin
                m_ready = 1'b1;
                m_valid = 1'b1;
                for (int i = 0; i < m_d; i++) m_hist.push_back('0);
            end
        end else if (en && m_ready) begin
            m_hist.push_back({re, im});
            m_acc++;
            if (m_hist.size() > m_d) begin
                s       = m_hist.pop_front();
                m_re    = s[2*WIDTH-1:WIDTH];
                m_im    = s[WIDTH-1:0];
                m_valid = 1'b1;
                m_known = 1'b1;
            end else begin
                m_known = 1'b0;
            end
        end
        x.edge_no = edge_cnt + 1;
        x.ready   = m_ready;
        x.valid   = m_valid;
        x.known   = m_known;
        x.re      = m_re;
        x.im      = m_im;
        x.wptr    = m_acc % m_d;
        sb.push_back(x);
        @(negedge clock);
    endtask

    task automatic load(input logic [AW:0] dep, input logic en);
        step(1'b1, en, 1'b1, dep, WIDTH'($urandom), WIDTH'($urandom));
    endtask

    task automatic run(input int n, input int en_pct);
        for (int i = 0; i < n; i++)
            step(1'b1, ($urandom_range(99) < en_pct), 1'b0, '0,
                 WIDTH'($urandom), WIDTH'($urandom));
    endtask

    initial begin
        m_d = MAX_DEPTH;
        model_flush();
        // reset
        step(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b1, 1'b0, '0, '0, '0);
        // D=4, ramp samples re=k, im=-k
        load((AW+1)'(4), 1'b0);
        run(MAX_DEPTH, 0);
        for (int k = 1; k <= 12; k++)
            step(1'b1, 1'b1, 1'b0, '0, WIDTH'(k), WIDTH'(-k));
        // D=4, enable toggling 1010...
        for (int k = 0; k < 20; k++)
            step(1'b1, k[0] == 1'b0, 1'b0, '0, WIDTH'($urandom), WIDTH'($urandom));
        // D=8 in RUN, then depth_load D=2 together with enable
        load((AW+1)'(8), 1'b0);
        run(MAX_DEPTH + 20, 100);
        load((AW+1)'(2), 1'b1);
        run(MAX_DEPTH + 10, 100);
        // depth clamps
        load((AW+1)'(0), 1'b0);
        run(MAX_DEPTH + 30, 70);
        load((AW+1)'(MAX_DEPTH + 1), 1'b0);
        run(MAX_DEPTH + 200, 80);
        // reset pulse mid-run
        step(1'b0, 1'b1, 1'b0, '0, WIDTH'($urandom), WIDTH'($urandom));
        run(MAX_DEPTH + 80, 90);
        // randomized mix of loads, resets and enables
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(149) == 0)
                load((AW+1)'($urandom), $urandom_range(1) == 1);
            else if ($urandom_range(599) == 0)
                step(1'b0, 1'b1, 1'b0, '0, '0, '0);
            else
                run(1, 75);
        end
        run(3, 0);
        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/delay_buffer_var.md
Name: delay_buffer_var

Overview:
- Circular-RAM complex delay line for the radix-4 SDF pipeline, replacing fixed shift-register delays.
- Delay D is selectable at runtime (1..MAX_DEPTH words), so one instance serves several FFT sizes.
- Adds fill tracking (out_valid), a flush-on-reconfigure sequence and a ready flag.

Parameters:
- MAX_DEPTH, 64, maximum delay in words; power of two, >= 2.
- WIDTH, 32, bits per real/imag component.
- AW, $clog2(MAX_DEPTH), address/pointer width (derived, not overridden).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- enable  in  1  advance the line by one sample when high and ready=1.
- depth  in  AW+1  requested delay D, sampled on depth_load.
- depth_load  in  1  one-cycle pulse: latch depth and flush.
- input_real  in  WIDTH  sample real part.
- input_imag  in  WIDTH  sample imag part.
- out_real  out  WIDTH  delayed real part (registered).
- out_imag  out  WIDTH  delayed imag part (registered).
- out_valid  out  1  outputs carry a real delayed sample.
- ready  out  1  block accepts enable.

Behaviour:
- Reset (reset_n=0 at posedge): D_reg=MAX_DEPTH, wptr=0, fill=0, out_real=0, out_imag=0, out_valid=0, ready=1 (macro off), state FILL.
- Storage: two MAX_DEPTH x WIDTH arrays (re/im), read-before-write at the same address.
- On accepted enable (enable & ready & !depth_load):
  - out_real/out_imag <= mem[wptr];
  - mem[wptr] <= input;
  - wptr <= (wptr == D_reg-1) ? 0 : wptr+1.
- Latency: the sample written on accepted enable k appears on the outputs after accepted enable k+D. Outputs hold when enable is low.
- Depth clamp: depth=0 latches as 1; depth>MAX_DEPTH latches as MAX_DEPTH.
- States (macro off):
  - FILL: fill counts accepted enables. When an enable is accepted with fill == D_reg, out_valid goes high in the same update and the state moves to RUN.
  - RUN: out_valid stays 1. Only depth_load or reset leaves RUN.
- depth_load (any state):
  - D_reg <= clamped depth; wptr=0; fill=0; out_valid=0; outputs cleared to 0; state FILL.
  - depth_load has priority over a simultaneous enable; that input sample is dropped.
- Wrap-around: wptr never reaches D_reg; unused addresses above D_reg-1 are untouched.
- D=1: behaves as a single register; out_valid goes high on the second accepted enable.
- enable while ready=0: ignored entirely; no pointer, memory or output change.
- Reset mid-operation: reset overrides depth_load and enable. Memory contents are not cleared (macro off).

Optional Feature:
- Macro DELAY_BUFFER_CLEAR_EN.
- Defined:
  - Adds state CLEAR, entered on reset and on every depth_load.
  - CLEAR writes zero to address 0..MAX_DEPTH-1, one address per cycle, with ready=0 and out_valid=0. It lasts exactly MAX_DEPTH cycles.
  - On exit: wptr=0, ready=1, state RUN with out_valid=1. The first D outputs are zeros (zero-padded pipeline prime).
  - depth_load during CLEAR restarts CLEAR at address 0 with the new D.
- Undefined: no CLEAR state, ready is constant 1 after reset, and out_valid follows FILL/RUN.

Test Plan:
- Reset, depth_load D=4, enable every cycle with samples re=1..12, im=-re -> out_valid first high on the enable carrying sample 5, with out_real=1; thereafter out_real = sample-4 each cycle.
- D=4, enable toggled 1010... -> output advances only on enabled cycles; delay is 4 accepted samples, not 4 clocks; outputs hold on idle cycles.
- In RUN with D=8, depth_load with depth=2 together with enable -> that sample is dropped, out_valid=0, outputs=0; the next 2 enables refill; the 3rd enable outputs the first post-load sample.
- depth=0 and depth=MAX_DEPTH+1 -> behave as D=1 and D=MAX_DEPTH respectively; wptr wraps at D-1 (check address sequence 0..D-1,0).
- reset_n low for one cycle mid-RUN -> next cycle outputs=0, out_valid=0, D_reg=MAX_DEPTH.
- DELAY_BUFFER_CLEAR_EN defined, reset then depth_load D=4 -> ready=0 for 64 cycles; then ready=1 and out_valid=1; the first 4 enables output 0+0j and the 5th outputs the first input sample.
